// File: rtl/spm_scan_pkg.sv
// Shared scan types, Q31 limits and saturation helpers for the SPM scan/control path.
// Latency: n/a (package only).
// Backpressure: n/a.
package spm_scan_pkg;

    localparam int Q_W = 32;

    // Positions are kept symmetric: the most negative code is never produced.
    localparam logic signed [Q_W-1:0] Q31_MAX    = 32'sh7FFF_FFFF;
    localparam logic signed [Q_W-1:0] Q31_MIN    = 32'sh8000_0001;
    localparam logic signed [Q_W:0]   Q31_MAX_33 = 33'sh0_7FFF_FFFF;
    localparam logic signed [Q_W:0]   Q31_MIN_33 = 33'sh1_8000_0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_FWD   = 3'd2,
        ST_REV   = 3'd3,
        ST_YSTEP = 3'd4
    } scan_state_t;

    function automatic logic signed [Q_W:0] sext33(input logic signed [Q_W-1:0] a);
        return {a[Q_W-1], a};
    endfunction

    function automatic logic signed [Q_W-1:0] sat33to32(input logic signed [Q_W:0] v);
        if (v > Q31_MAX_33) begin
            return Q31_MAX;
        end else if (v < Q31_MIN_33) begin
            return Q31_MIN;
        end else begin
            return v[Q_W-1:0];
        end
    endfunction

endpackage

// File: rtl/axis_raster_scan_gen_if.sv
// Xs/Ys coordinate streams leaving the raster generator.
// Latency: n/a (wires only).
// Backpressure: none; no tready, words are continuous once tvalid rises.
interface axis_raster_scan_gen_if #(
    parameter int DW = 32
);
    logic [DW-1:0] M_AXIS_Xs_tdata;
    logic          M_AXIS_Xs_tvalid;
    logic [DW-1:0] M_AXIS_Ys_tdata;
    logic          M_AXIS_Ys_tvalid;

    modport master (
        output M_AXIS_Xs_tdata,
        output M_AXIS_Xs_tvalid,
        output M_AXIS_Ys_tdata,
        output M_AXIS_Ys_tvalid
    );

    modport slave (
        input M_AXIS_Xs_tdata,
        input M_AXIS_Xs_tvalid,
        input M_AXIS_Ys_tdata,
        input M_AXIS_Ys_tvalid
    );
endinterface

// File: rtl/scan_step_adjuster.sv
// One-axis slew limiter: next position steps toward target by at most max_step (0 acts as 1).
// Latency: combinational.
// Backpressure: none.
module scan_step_adjuster
    import spm_scan_pkg::*;
(
    input  logic signed [Q_W-1:0] pos,
    input  logic signed [Q_W-1:0] target,
    input  logic        [Q_W-1:0] max_step,
    output logic signed [Q_W-1:0] next_pos
);

    logic signed [Q_W:0] diff;
    logic signed [Q_W:0] step;
    logic signed [Q_W:0] nxt;

    // Both operands lie within +/-(2^31-1), so the 33-bit difference cannot overflow,
    // and pos+/-step is only taken when it lands strictly short of the target.
    always_comb begin
        step = (max_step == '0) ? 33'sd1 : $signed({1'b0, max_step});
        diff = sext33(target) - sext33(pos);
        nxt  = sext33(target);
        if (diff > step) begin
            nxt = sext33(pos) + step;
        end else if (diff < -step) begin
            nxt = sext33(pos) - step;
        end
        next_pos = sat33to32(nxt);
    end

endmodule

// File: rtl/axis_raster_scan_gen.sv
// Bidirectional raster generator: move to start, forward line, reverse line, Y step; streams Xs/Ys.
// Latency: positions update at the edge closing a tick cycle; pix_strobe is high during that tick cycle.
// Backpressure: none; Xs/Ys are continuous (tvalid high from the first clock after reset).
module axis_raster_scan_gen
    import spm_scan_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NW     = 16,
    parameter int DECI_W = 16
) (
    input  logic                   a_clk,
    input  logic                   a_resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NW-1:0]          n_x,
    input  logic [NW-1:0]          n_y,
    input  logic [DW-1:0]          dx,
    input  logic [DW-1:0]          dy,
    input  logic [DW-1:0]          x_start,
    input  logic [DW-1:0]          y_start,
    input  logic [DW-1:0]          move_step,
    input  logic [DECI_W-1:0]      deci,
    axis_raster_scan_gen_if.master m_axis,
    output logic                   pix_strobe,
    output logic                   pix_dir,
    output logic [NW-1:0]          line,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    scan_state_t state_q, state_d;

    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic signed [DW-1:0] adj_x, adj_y;
    logic [NW-1:0]        ix_q, ix_d, iy_q, iy_d;
    logic [DECI_W-1:0]    tick_cnt_q;
    logic                 tick;
    logic                 latch_cfg;
    logic                 done_q, done_d, aborted_q, aborted_d;
    logic                 tvalid_q;

    logic [NW-1:0]        cfg_n_x_q, cfg_n_y_q;
    logic signed [DW-1:0] cfg_dx_q, cfg_dy_q, cfg_x_start_q, cfg_y_start_q;
    logic [DW-1:0]        cfg_move_step_q;
    logic [DECI_W-1:0]    cfg_deci_q;

    assign tick = (tick_cnt_q == cfg_deci_q);

    scan_step_adjuster u_adj_x (
        .pos      (x_q),
        .target   (cfg_x_start_q),
        .max_step (cfg_move_step_q),
        .next_pos (adj_x)
    );

    scan_step_adjuster u_adj_y (
        .pos      (y_q),
        .target   (cfg_y_start_q),
        .max_step (cfg_move_step_q),
        .next_pos (adj_y)
    );

    // State register.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next datapath values; stop in any busy state overrides everything.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        latch_cfg = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (n_x != '0) && (n_y != '0)) begin
                    latch_cfg = 1'b1;
                    state_d   = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if ((x_q == cfg_x_start_q) && (y_q == cfg_y_start_q)) begin
                        ix_d    = '0;
                        iy_d    = '0;
                        state_d = ST_FWD;
                    end else begin
                        x_d = adj_x;
                        y_d = adj_y;
                    end
                end
            end
            ST_FWD: begin
                if (tick) begin
                    if (ix_q == cfg_n_x_q - NW'(1)) begin
                        state_d = ST_REV;
                    end else begin
                        x_d  = sat33to32(sext33(x_q) + sext33(cfg_dx_q));
                        ix_d = ix_q + NW'(1);
                    end
                end
            end
            ST_REV: begin
                if (tick) begin
                    if (ix_q == '0) begin
                        if (iy_q == cfg_n_y_q - NW'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_YSTEP;
                        end
                    end else begin
                        x_d  = sat33to32(sext33(x_q) - sext33(cfg_dx_q));
                        ix_d = ix_q - NW'(1);
                    end
                end
            end
            ST_YSTEP: begin
                if (tick) begin
                    y_d     = sat33to32(sext33(y_q) + sext33(cfg_dy_q));
                    iy_d    = iy_q + NW'(1);
                    state_d = ST_FWD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && stop) begin
            state_d   = ST_IDLE;
            x_d       = x_q;
            y_d       = y_q;
            ix_d      = ix_q;
            iy_d      = iy_q;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    // Positions, counters, pulses and the config snapshot taken at start.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            x_q             <= '0;
            y_q             <= '0;
            ix_q            <= '0;
            iy_q            <= '0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            tvalid_q        <= 1'b0;
            cfg_n_x_q       <= '0;
            cfg_n_y_q       <= '0;
            cfg_dx_q        <= '0;
            cfg_dy_q        <= '0;
            cfg_x_start_q   <= '0;
            cfg_y_start_q   <= '0;
            cfg_move_step_q <= '0;
            cfg_deci_q      <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            tvalid_q  <= 1'b1;
            if (latch_cfg) begin
                cfg_n_x_q       <= n_x;
                cfg_n_y_q       <= n_y;
                cfg_dx_q        <= $signed(dx);
                cfg_dy_q        <= $signed(dy);
                // Clamp targets into the symmetric range so MOVE can always land on them.
                cfg_x_start_q   <= sat33to32(sext33($signed(x_start)));
                cfg_y_start_q   <= sat33to32(sext33($signed(y_start)));
                cfg_move_step_q <= move_step;
                cfg_deci_q      <= deci;
            end
        end
    end

    // Tick divider: free-runs only while busy, restarting from zero on every scan.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            tick_cnt_q <= '0;
        end else if (latch_cfg || (state_q == ST_IDLE) || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + DECI_W'(1);
        end
    end

    assign pix_strobe = tick && !stop && ((state_q == ST_FWD) || (state_q == ST_REV));
    assign pix_dir    = (state_q == ST_REV);
    assign line       = iy_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign aborted    = aborted_q;

    assign m_axis.M_AXIS_Xs_tdata  = x_q;
    assign m_axis.M_AXIS_Xs_tvalid = tvalid_q;
    assign m_axis.M_AXIS_Ys_tdata  = y_q;
    assign m_axis.M_AXIS_Ys_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_raster_scan_gen.sv
// Directed bench for the raster scan generator: vector table of scans plus hand-built corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_raster_scan_gen;

    logic        a_clk;
    logic        a_resetn;
    logic        start;
    logic        stop;
    logic [15:0] n_x;
    logic [15:0] n_y;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] x_start;
    logic [31:0] y_start;
    logic [31:0] move_step;
    logic [15:0] deci;
    logic        pix_strobe;
    logic        pix_dir;
    logic [15:0] line;
    logic        busy;
    logic        done;
    logic        aborted;

    axis_raster_scan_gen_if #(.DW(32)) m_axis ();

    axis_raster_scan_gen #(.DW(32), .NW(16), .DECI_W(16)) dut (
        .a_clk      (a_clk),
        .a_resetn   (a_resetn),
        .start      (start),
        .stop       (stop),
        .n_x        (n_x),
        .n_y        (n_y),
        .dx         (dx),
        .dy         (dy),
        .x_start    (x_start),
        .y_start    (y_start),
        .move_step  (move_step),
        .deci       (deci),
        .m_axis     (m_axis),
        .pix_strobe (pix_strobe),
        .pix_dir    (pix_dir),
        .line       (line),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    typedef struct {
        logic [15:0] n_x;
        logic [15:0] n_y;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [31:0] ms;
        logic [15:0] deci;
        int          exp_cyc;
        int          exp_stb;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [31:0] exp_endx;
        logic [31:0] exp_endy;
    } vec_t;

    vec_t vecs [6];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tx_q [$];
    logic [31:0] ty_q [$];
    bit          ts_q [$];
    logic [31:0] sx_q [$];
    logic [31:0] sy_q [$];
    bit          sd_q [$];

    logic [31:0] v0_sx [16];
    logic [31:0] v2_tx [6];
    logic [31:0] v2_ty [6];
    logic [31:0] v4_sx [8];

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q [$], input int k);
        if (k < q.size()) return q[k];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic run_scan(input vec_t v, input int limit, output int cyc, output bit done_ok);
        int early;
        @(negedge a_clk);
        n_x       = v.n_x;
        n_y       = v.n_y;
        dx        = v.dx;
        dy        = v.dy;
        x_start   = v.xs;
        y_start   = v.ys;
        move_step = v.ms;
        deci      = v.deci;
        start     = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        tx_q.delete();
        ty_q.delete();
        ts_q.delete();
        sx_q.delete();
        sy_q.delete();
        sd_q.delete();
        cyc   = 0;
        early = 0;
        while (busy && cyc < limit) begin
            tx_q.push_back(m_axis.M_AXIS_Xs_tdata);
            ty_q.push_back(m_axis.M_AXIS_Ys_tdata);
            ts_q.push_back(pix_strobe);
            if (pix_strobe) begin
                sx_q.push_back(m_axis.M_AXIS_Xs_tdata);
                sy_q.push_back(m_axis.M_AXIS_Ys_tdata);
                sd_q.push_back(pix_dir);
            end
            if (done) early++;
            cyc++;
            @(negedge a_clk);
        end
        done_ok = (done === 1'b1) && (early == 0) && (busy === 1'b0);
    endtask

    initial begin
        int          cyc;
        bit          dok;
        int          viol;
        int          xchg;
        int          wait_cnt;
        int          done_cnt;
        bit          exp_s;
        logic [31:0] fx;
        logic [31:0] lx;

        //           n_x    n_y    dx          dy          xs            ys            ms            deci   cyc stb first         last          endx          endy
        vecs[0] = '{16'd4, 16'd2, 32'h100,    32'h1000,   32'h0,        32'h0,        32'h1,        16'd0, 18, 16, 32'h0,        32'h0,        32'h0,        32'h1000};
        vecs[1] = '{16'd1, 16'd1, 32'h0,      32'h0,      32'h0,        32'h0,        32'h1000,     16'd0,  4,  2, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[2] = '{16'd2, 16'd1, 32'h10,     32'h0,      32'h1000,     32'hFFFFF800, 32'h400,      16'd0,  9,  4, 32'h1000,     32'h1000,     32'h1000,     32'hFFFFF800};
        vecs[3] = '{16'd3, 16'd2, 32'h20,     32'h40,     32'h1000,     32'hFFFFF800, 32'h1,        16'd3, 56, 12, 32'h1000,     32'h1000,     32'h1000,     32'hFFFFF840};
        vecs[4] = '{16'd4, 16'd1, 32'h100,    32'h0,      32'h7FFFFF00, 32'h0,        32'h7FFFFFFF, 16'd0, 10,  8, 32'h7FFFFF00, 32'h7FFFFCFF, 32'h7FFFFCFF, 32'h0};
        vecs[5] = '{16'd1, 16'd1, 32'h0,      32'h0,      32'h7FFFFD01, 32'h0,        32'h0,        16'd0,  5,  2, 32'h7FFFFD01, 32'h7FFFFD01, 32'h7FFFFD01, 32'h0};

        v0_sx = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h300, 32'h200, 32'h100, 32'h0,
                  32'h0, 32'h100, 32'h200, 32'h300, 32'h300, 32'h200, 32'h100, 32'h0};
        v2_tx = '{32'h0, 32'h400, 32'h800, 32'hC00, 32'h1000, 32'h1000};
        v2_ty = '{32'h0, 32'hFFFFFC00, 32'hFFFFF800, 32'hFFFFF800, 32'hFFFFF800, 32'hFFFFF800};
        v4_sx = '{32'h7FFFFF00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                  32'h7FFFFFFF, 32'h7FFFFEFF, 32'h7FFFFDFF, 32'h7FFFFCFF};

        a_resetn  = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        n_x       = '0;
        n_y       = '0;
        dx        = '0;
        dy        = '0;
        x_start   = '0;
        y_start   = '0;
        move_step = '0;
        deci      = '0;

        #2 a_resetn = 1'b0;
        #1;
        chk("reset x", m_axis.M_AXIS_Xs_tdata, 32'h0);
        chk("reset y", m_axis.M_AXIS_Ys_tdata, 32'h0);
        chk("reset tvalid", {31'h0, m_axis.M_AXIS_Xs_tvalid}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset line", {16'h0, line}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        chk("reset strobe", {31'h0, pix_strobe}, 32'h0);

        repeat (3) @(negedge a_clk);
        a_resetn = 1'b1;
        @(negedge a_clk);
        chk("release xs tvalid", {31'h0, m_axis.M_AXIS_Xs_tvalid}, 32'h1);
        chk("release ys tvalid", {31'h0, m_axis.M_AXIS_Ys_tvalid}, 32'h1);
        chk("release busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i], 3000, cyc, dok);
            fx = (sx_q.size() > 0) ? sx_q[0] : 32'hxxxx_xxxx;
            lx = (sx_q.size() > 0) ? sx_q[sx_q.size()-1] : 32'hxxxx_xxxx;
            chk($sformatf("v%0d busy cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d strobes", i), sx_q.size(), vecs[i].exp_stb);
            chk($sformatf("v%0d first strobe x", i), fx, vecs[i].exp_first);
            chk($sformatf("v%0d last strobe x", i), lx, vecs[i].exp_last);
            chk($sformatf("v%0d end x", i), m_axis.M_AXIS_Xs_tdata, vecs[i].exp_endx);
            chk($sformatf("v%0d end y", i), m_axis.M_AXIS_Ys_tdata, vecs[i].exp_endy);
            chk($sformatf("v%0d done with busy fall", i), {31'h0, dok}, 32'h1);

            if (i == 0) begin
                for (int k = 0; k < 16; k++) begin
                    chk($sformatf("v0 strobe %0d x", k), qget(sx_q, k), v0_sx[k]);
                    chk($sformatf("v0 strobe %0d y", k), qget(sy_q, k), (k < 8) ? 32'h0 : 32'h1000);
                    chk($sformatf("v0 strobe %0d dir", k), (k < sd_q.size()) ? {31'h0, sd_q[k]} : 32'hx,
                        ((k % 8) >= 4) ? 32'h1 : 32'h0);
                end
                chk("v0 line after done", {16'h0, line}, 32'h1);
            end

            if (i == 2) begin
                for (int k = 0; k < 6; k++) begin
                    chk($sformatf("v2 move cycle %0d x", k), qget(tx_q, k), v2_tx[k]);
                    chk($sformatf("v2 move cycle %0d y", k), qget(ty_q, k), v2_ty[k]);
                    chk($sformatf("v2 move cycle %0d strobe", k),
                        (k < ts_q.size()) ? {31'h0, ts_q[k]} : 32'hx, (k == 5) ? 32'h1 : 32'h0);
                end
            end

            if (i == 3) begin
                viol = 0;
                xchg = 0;
                for (int k = 0; k < tx_q.size(); k++) begin
                    exp_s = ((k % 4) == 3) && (k >= 7) && (k != 31);
                    if (ts_q[k] != exp_s) viol++;
                    if (k > 0 && tx_q[k] != tx_q[k-1]) begin
                        xchg++;
                        if ((k % 4) != 0) viol++;
                    end
                end
                chk("v3 strobe/x timing violations", viol, 0);
                chk("v3 x change count", xchg, 8);
            end

            if (i == 4) begin
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("v4 sat strobe %0d x", k), qget(sx_q, k), v4_sx[k]);
                end
            end
        end

        // Stop in FWD at ix=2.
        @(negedge a_clk);
        n_x       = 16'd8;
        n_y       = 16'd2;
        dx        = 32'h100;
        dy        = 32'h10;
        x_start   = 32'h0;
        y_start   = 32'h0;
        move_step = 32'h7FFFFFFF;
        deci      = 16'd0;
        start     = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        repeat (4) @(negedge a_clk);
        chk("stop pre x", m_axis.M_AXIS_Xs_tdata, 32'h200);
        chk("stop pre busy", {31'h0, busy}, 32'h1);
        stop = 1'b1;
        @(negedge a_clk);
        stop = 1'b0;
        chk("stop busy", {31'h0, busy}, 32'h0);
        chk("stop aborted", {31'h0, aborted}, 32'h1);
        chk("stop x hold", m_axis.M_AXIS_Xs_tdata, 32'h200);
        chk("stop y hold", m_axis.M_AXIS_Ys_tdata, 32'h0);
        done_cnt = (done === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge a_clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("stop no done", done_cnt, 0);
        chk("stop aborted one-shot", {31'h0, aborted}, 32'h0);
        chk("stop x still held", m_axis.M_AXIS_Xs_tdata, 32'h200);

        // Ignored starts: n_y=0, n_x=0, start together with stop.
        n_x   = 16'd4;
        n_y   = 16'd0;
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        @(negedge a_clk);
        chk("start n_y=0 ignored", {31'h0, busy}, 32'h0);
        n_x   = 16'd0;
        n_y   = 16'd2;
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        @(negedge a_clk);
        chk("start n_x=0 ignored", {31'h0, busy}, 32'h0);
        n_x   = 16'd4;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start+stop busy", {31'h0, busy}, 32'h0);
        chk("start+stop aborted", {31'h0, aborted}, 32'h0);
        @(negedge a_clk);
        chk("ignored starts x", m_axis.M_AXIS_Xs_tdata, 32'h200);

        // Reset asserted in REV.
        n_x       = 16'd4;
        n_y       = 16'd1;
        dx        = 32'h100;
        dy        = 32'h0;
        x_start   = 32'h200;
        y_start   = 32'h300;
        move_step = 32'h7FFFFFFF;
        start     = 1'b1;
        @(negedge a_clk);
        start    = 1'b0;
        wait_cnt = 0;
        while (!(pix_strobe === 1'b1 && pix_dir === 1'b1) && wait_cnt < 50) begin
            @(negedge a_clk);
            wait_cnt++;
        end
        chk("rev reached", {31'h0, (wait_cnt < 50)}, 32'h1);
        chk("rev pre-reset x", m_axis.M_AXIS_Xs_tdata, 32'h500);
        chk("rev pre-reset y", m_axis.M_AXIS_Ys_tdata, 32'h300);
        a_resetn = 1'b0;
        #1;
        chk("mid reset x", m_axis.M_AXIS_Xs_tdata, 32'h0);
        chk("mid reset y", m_axis.M_AXIS_Ys_tdata, 32'h0);
        chk("mid reset tvalid", {31'h0, m_axis.M_AXIS_Xs_tvalid}, 32'h0);
        chk("mid reset busy", {31'h0, busy}, 32'h0);
        chk("mid reset line", {16'h0, line}, 32'h0);
        @(negedge a_clk);
        a_resetn = 1'b1;
        @(negedge a_clk);
        chk("post reset tvalid", {31'h0, m_axis.M_AXIS_Ys_tvalid}, 32'h1);
        chk("post reset busy", {31'h0, busy}, 32'h0);
        chk("post reset x", m_axis.M_AXIS_Xs_tdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_raster_scan_gen.md
Name: axis_raster_scan_gen

Overview:
- Upstream stage of the SPM control block. Generates the relative, unrotated scan coordinates Xs/Ys as continuous AXI-Stream words.
- Runs a bidirectional raster: move-to-start, forward line, reverse line, then Y step, repeated per line.
- Emits a per-pixel sample strobe for the data acquisition path.
- All positions are Q31 signed; the downstream block applies rotation, offsets and slope.

Parameters:
- DW, 32, coordinate width (Q31 signed)
- NW, 16, pixel/line counter width
- DECI_W, 16, step-period counter width

Ports:
- a_clk  in  1  clock
- a_resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a scan from IDLE
- stop  in  1  single-cycle pulse; aborts the scan
- n_x  in  NW  pixels per line
- n_y  in  NW  lines
- dx  in  DW  signed X increment per pixel
- dy  in  DW  signed Y increment per line
- x_start  in  DW  signed start X
- y_start  in  DW  signed start Y
- move_step  in  DW  unsigned max |Δ| per tick in MOVE; 0 is treated as 1
- deci  in  DECI_W  tick period is deci+1 clocks
- M_AXIS_Xs_tdata  out  DW  X coordinate
- M_AXIS_Xs_tvalid  out  1  valid
- M_AXIS_Ys_tdata  out  DW  Y coordinate
- M_AXIS_Ys_tvalid  out  1  valid
- pix_strobe  out  1  one-cycle pulse per sampled pixel
- pix_dir  out  1  0 = forward, 1 = reverse; valid with pix_strobe
- line  out  NW  current line index
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when stop is taken

Behaviour:
- Reset (async assert, sync release): state IDLE; X=Y=0; line=0; all pulses 0; busy=0; tvalid=0.
- tvalid goes to 1 on the first clock after release and stays 1.
- Consumer has no tready; data is continuous.
- Config latch: on start in IDLE with n_x≠0 and n_y≠0, all config inputs are latched, the tick counter clears and the state goes to MOVE.
  - start with n_x=0 or n_y=0 is ignored.
  - start while busy is ignored.
- Tick: an internal counter asserts tick every deci+1 clocks. deci=0 gives a tick every clock.
- States:
  - IDLE: positions hold.
  - MOVE: on each tick, X and Y each step toward x_start/y_start by min(|target−pos|, move_step), using 33-bit arithmetic (adjuster semantics). When X==x_start and Y==y_start at a tick: ix=0, iy=0, go to FWD.
  - FWD: on each tick, pix_strobe=1 with pix_dir=0. If ix==n_x−1, go to REV with X held. Otherwise X+=dx and ix++.
  - REV: on each tick, pix_strobe=1 with pix_dir=1. If ix==0: when iy==n_y−1, pulse done and go to IDLE; otherwise go to YSTEP. Otherwise X−=dx and ix−−.
  - YSTEP: on the next tick, Y+=dy, iy++, go to FWD.
- line mirrors iy.
- Result per line: n_x forward strobes and n_x reverse strobes. The turnaround pixel is sampled twice, once per direction.
- Arithmetic: every update is computed at DW+1 bits and saturated to ±(2^31−1). The output never wraps.
- Latency: a coordinate change appears on tdata in the same clock edge as the tick. pix_strobe is asserted in that same cycle and refers to the pre-update position.
- stop in any busy state: next cycle state=IDLE, aborted=1, positions hold (no jump), no done pulse.
- stop in IDLE has no effect.
- Simultaneous start and stop in IDLE: stop wins; the scan does not start.
- Reset mid-scan: immediate return to reset values.
- Config inputs changing mid-scan have no effect until the next start.

Decomposition:
- Shared package spm_scan_pkg:
  - state enum (IDLE, MOVE, FWD, REV, YSTEP)
  - Q31 max/min constants
  - sat33to32 function, also reusable by the control block
- Sub-module scan_step_adjuster: one axis, pos/target/max_step in, saturated next-position out. Instantiated twice for MOVE.

Test Plan:
- deci=0, n_x=4, n_y=2, dx=0x100, dy=0x1000, start (0,0), already at start:
  - X sequence 0,100,200,300,300,200,100,0 then Y=0x1000 and the same again.
  - 16 strobes; done after the last reverse strobe; busy falls in the same cycle.
- MOVE: pos (0,0) → target (0x1000,−0x800), move_step=0x400, deci=0:
  - X reaches target in 4 ticks, Y in 2 ticks.
  - FWD entered after both match; no overshoot.
- Saturation: x_start=0x7FFFFF00, dx=0x100, n_x=4:
  - X = 0x7FFFFF00, then 0x7FFFFFFF held; no sign flip.
- deci=3: exactly one X change per 4 clocks.
  - Strobe spacing 4 clocks; strobe count unchanged.
- stop in FWD at ix=2: next cycle IDLE, aborted=1, X holds its current value, done never asserted.
  - start with n_y=0 is ignored: busy stays 0.
- Reset asserted mid-REV:
  - outputs go to 0 asynchronously and tvalid=0.
  - after release, tvalid=1 and state IDLE.
